// File: rtl/traffic_light_pkg.sv
// Shared traffic-light encodings: lamp/phase bit indices, the controller's one-hot state type,
// and the monitor's state type, which adds an all-zero SYNC code for the unlocked case.
package traffic_light_pkg;

    localparam int unsigned GREEN_BIT           = 0;
    localparam int unsigned YELLOW_TO_GREEN_BIT = 1;
    localparam int unsigned YELLOW_TO_RED_BIT   = 2;
    localparam int unsigned RED_BIT             = 3;

    typedef enum logic [3:0] {
        GREEN           = 4'b0001,
        YELLOW_TO_GREEN = 4'b0010,
        YELLOW_TO_RED   = 4'b0100,
        RED             = 4'b1000
    } state_t;

    localparam logic [3:0] SYNC_CODE = 4'b0000;

    // Monitor states reuse the controller's one-hot codes so the state register is the phase output.
    typedef enum logic [3:0] {
        MON_SYNC  = SYNC_CODE,
        MON_GREEN = 4'b0001,
        MON_Y2G   = 4'b0010,
        MON_Y2R   = 4'b0100,
        MON_RED   = 4'b1000
    } mon_state_t;

    function automatic mon_state_t mon_successor(mon_state_t s);
        case (s)
            MON_RED:   return MON_Y2G;
            MON_Y2G:   return MON_GREEN;
            MON_GREEN: return MON_Y2R;
            MON_Y2R:   return MON_RED;
            default:   return MON_SYNC;
        endcase
    endfunction

endpackage

// File: rtl/traffic_dwell_timer.sv
// Per-phase dwell counter: loads 1 on phase entry, counts held samples and saturates at
// MAX_DWELL+1, so too_long fires only on the single hold that reaches saturation.
module traffic_dwell_timer #(
    parameter int unsigned MIN_DWELL = 1,
    parameter int unsigned MAX_DWELL = 1,
    parameter int unsigned COUNT_W   = $clog2(MAX_DWELL + 2)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               load,
    input  logic               hold,
    output logic               too_short,
    output logic               too_long,
    output logic [COUNT_W-1:0] count
);

    localparam logic [COUNT_W-1:0] MinVal = COUNT_W'(MIN_DWELL);
    localparam logic [COUNT_W-1:0] MaxVal = COUNT_W'(MAX_DWELL);
    localparam logic [COUNT_W-1:0] SatVal = COUNT_W'(MAX_DWELL + 1);

    logic [COUNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = COUNT_W'(1);
        end else if (hold && (count_q != SatVal)) begin
            count_d = count_q + COUNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign too_short = (count_q < MinVal);
    assign too_long  = hold && (count_q == MaxVal);
    assign count     = count_q;

endmodule

// File: rtl/traffic_light_monitor.sv
// Receive-side checker: decodes red/yellow/green back into the four-phase state and flags
// illegal lamp combinations, illegal phase sequences and dwell violations; counts full cycles.
module traffic_light_monitor
    import traffic_light_pkg::*;
#(
    parameter int unsigned MIN_DWELL = 1,
    parameter int unsigned MAX_DWELL = 1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             red,
    input  logic             yellow,
    input  logic             green,
    input  logic             clr_err,
    output logic [3:0]       phase,
    output logic             in_sync,
    output logic             err_combo,
    output logic             err_seq,
    output logic             err_dwell,
    output logic [2:0]       err_status,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int unsigned DWELL_W = $clog2(MAX_DWELL + 2);

    logic [2:0]  lamp;
    logic        lamp_onehot;
    mon_state_t  state_q, state_d, target;
    logic        combo_d, seq_d, dwell_d, inc_d;
    logic        in_sync_q, combo_q, seq_q, dwell_q;
    logic [2:0]  status_q, status_d;
    logic [CNT_W-1:0] cycle_q;

    logic               tmr_clear, tmr_load, tmr_hold;
    logic               too_short, too_long, dwell_active;
    logic [DWELL_W-1:0] dwell_cnt;

    assign lamp        = {red, yellow, green};
    assign lamp_onehot = (lamp == 3'b100) || (lamp == 3'b010) || (lamp == 3'b001);

    // A zero count means the phase was never timed, so no dwell verdict applies.
    assign dwell_active = (dwell_cnt != '0);

    traffic_dwell_timer #(
        .MIN_DWELL (MIN_DWELL),
        .MAX_DWELL (MAX_DWELL),
        .COUNT_W   (DWELL_W)
    ) u_dwell (
        .clk       (clk),
        .reset     (reset),
        .clear     (tmr_clear),
        .load      (tmr_load),
        .hold      (tmr_hold),
        .too_short (too_short),
        .too_long  (too_long),
        .count     (dwell_cnt)
    );

    // Phase implied by a one-hot lamp; yellow is resolved by the lamp it follows.
    always_comb begin
        target = state_q;
        if (red) begin
            target = MON_RED;
        end else if (green) begin
            target = MON_GREEN;
        end else if (state_q == MON_RED) begin
            target = MON_Y2G;
        end else if (state_q == MON_GREEN) begin
            target = MON_Y2R;
        end
    end

    always_comb begin
        state_d   = state_q;
        combo_d   = 1'b0;
        seq_d     = 1'b0;
        dwell_d   = 1'b0;
        inc_d     = 1'b0;
        tmr_clear = 1'b0;
        tmr_load  = 1'b0;
        tmr_hold  = 1'b0;
        if (!lamp_onehot) begin
            combo_d   = 1'b1;
            tmr_clear = 1'b1;
            state_d   = MON_SYNC;
        end else if (state_q == MON_SYNC) begin
            if (yellow) begin
                tmr_clear = 1'b1;
            end else begin
                state_d  = target;
                tmr_load = 1'b1;
            end
        end else if (target == state_q) begin
            tmr_hold = 1'b1;
            dwell_d  = dwell_active && too_long;
        end else if (target == mon_successor(state_q)) begin
            state_d  = target;
            tmr_load = 1'b1;
            dwell_d  = dwell_active && too_short;
            inc_d    = (state_q == MON_Y2R);
        end else begin
            state_d  = target;
            tmr_load = 1'b1;
            seq_d    = 1'b1;
        end
    end

    // A new pulse overrides a simultaneous clear of the same bit.
    assign status_d = (clr_err ? 3'b000 : status_q) | {dwell_d, seq_d, combo_d};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= MON_SYNC;
            in_sync_q <= 1'b0;
            combo_q   <= 1'b0;
            seq_q     <= 1'b0;
            dwell_q   <= 1'b0;
            status_q  <= 3'b000;
            cycle_q   <= '0;
        end else begin
            state_q   <= state_d;
            in_sync_q <= (state_d != MON_SYNC);
            combo_q   <= combo_d;
            seq_q     <= seq_d;
            dwell_q   <= dwell_d;
            status_q  <= status_d;
            cycle_q   <= cycle_q + CNT_W'(inc_d);
        end
    end

    assign phase       = state_q;
    assign in_sync     = in_sync_q;
    assign err_combo   = combo_q;
    assign err_seq     = seq_q;
    assign err_dwell   = dwell_q;
    assign err_status  = status_q;
    assign cycle_count = cycle_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: two instances (default dwell 1/1 and 2/3) share stimulus and
// are compared against an integer-level model of the phase rules.
module tb_traffic_light_monitor;

    localparam logic [2:0] LR = 3'b100, LY = 3'b010, LG = 3'b001;

    logic clk = 1'b0;
    logic reset = 1'b1, red = 1'b0, yellow = 1'b0, green = 1'b0, clr_err = 1'b0;

    logic [3:0]  phase_a, phase_b;
    logic        in_sync_a, in_sync_b, err_combo_a, err_combo_b;
    logic        err_seq_a, err_seq_b, err_dwell_a, err_dwell_b;
    logic [2:0]  err_status_a, err_status_b;
    logic [15:0] cycle_count_a, cycle_count_b;

    always #5 clk = ~clk;

    traffic_light_monitor dut_a (
        .clk (clk), .reset (reset), .red (red), .yellow (yellow), .green (green),
        .clr_err (clr_err), .phase (phase_a), .in_sync (in_sync_a), .err_combo (err_combo_a),
        .err_seq (err_seq_a), .err_dwell (err_dwell_a), .err_status (err_status_a),
        .cycle_count (cycle_count_a)
    );

    traffic_light_monitor #(.MIN_DWELL(2), .MAX_DWELL(3), .CNT_W(16)) dut_b (
        .clk (clk), .reset (reset), .red (red), .yellow (yellow), .green (green),
        .clr_err (clr_err), .phase (phase_b), .in_sync (in_sync_b), .err_combo (err_combo_b),
        .err_seq (err_seq_b), .err_dwell (err_dwell_b), .err_status (err_status_b),
        .cycle_count (cycle_count_b)
    );

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: phase as its one-hot value (0 = unlocked), dwell as an unbounded count.
    int         min_d[2] = '{1, 2};
    int         max_d[2] = '{1, 3};
    int         m_phase[2], m_dwell[2], m_cycles[2];
    bit         m_combo[2], m_seq[2], m_dw[2];
    logic [2:0] m_status[2];
    logic [2:0] last_lamp;

    task automatic model_step(input int i, input logic [2:0] l, input logic c, input logic r);
        int tgt, nxt;
        m_combo[i] = 0; m_seq[i] = 0; m_dw[i] = 0;
        if (r) begin
            m_phase[i] = 0; m_dwell[i] = 0; m_cycles[i] = 0; m_status[i] = 3'b000;
            return;
        end
        if (l != LR && l != LY && l != LG) begin
            m_combo[i] = 1; m_phase[i] = 0; m_dwell[i] = 0;
        end else if (m_phase[i] == 0) begin
            if (l != LY) begin
                m_phase[i] = l[2] ? 8 : 1;
                m_dwell[i] = 1;
            end
        end else begin
            tgt = l[2] ? 8 : l[0] ? 1 : (m_phase[i] == 8) ? 2 : (m_phase[i] == 1) ? 4 : m_phase[i];
            nxt = (m_phase[i] == 8) ? 2 : (m_phase[i] == 2) ? 1 : (m_phase[i] == 1) ? 4 : 8;
            if (tgt == m_phase[i]) begin
                m_dwell[i]++;
                if (m_dwell[i] == max_d[i] + 1) m_dw[i] = 1;
            end else begin
                if (tgt == nxt) begin
                    if (m_dwell[i] < min_d[i]) m_dw[i] = 1;
                    if (m_phase[i] == 4) m_cycles[i]++;
                end else begin
                    m_seq[i] = 1;
                end
                m_phase[i] = tgt;
                m_dwell[i] = 1;
            end
        end
        m_status[i] = (c ? 3'b000 : m_status[i]) | {m_dw[i], m_seq[i], m_combo[i]};
    endtask

    function automatic logic [26:0] exp_vec(input int i);
        return {4'(m_phase[i]), (m_phase[i] != 0), m_combo[i], m_seq[i], m_dw[i], m_status[i],
                16'(m_cycles[i])};
    endfunction

    function automatic logic [26:0] obs_vec(input int i);
        if (i == 0)
            return {phase_a, in_sync_a, err_combo_a, err_seq_a, err_dwell_a, err_status_a,
                    cycle_count_a};
        return {phase_b, in_sync_b, err_combo_b, err_seq_b, err_dwell_b, err_status_b,
                cycle_count_b};
    endfunction

    // Drive one sample, advance both models on the edge, settle 1 time unit past it.
    task automatic step(input logic [2:0] l, input logic c, input logic r);
        {red, yellow, green} = l;
        clr_err = c;
        reset = r;
        last_lamp = l;
        @(posedge clk);
        model_step(0, l, c, r);
        model_step(1, l, c, r);
        #1;
    endtask

    task automatic test_reset();
        step(3'b111, 1'b0, 1'b1);
        step(LR, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (obs_vec(i) !== 27'd0) begin
                n_fail++;
                $display("FAIL reset dut%0d: got %h, expected 0", i, obs_vec(i));
            end
        end
    endtask

    task automatic test_cycles();
        logic [2:0] seq[13] = '{LR, LY, LG, LY, LR, LY, LG, LY, LR, LY, LG, LY, LR};
        logic [3:0] ph[13]  = '{8, 2, 1, 4, 8, 2, 1, 4, 8, 2, 1, 4, 8};
        step(3'b000, 1'b0, 1'b1);
        for (int k = 0; k < 13; k++) begin
            step(seq[k], 1'b0, 1'b0);
            n_cmp++;
            if (phase_a !== ph[k] || in_sync_a !== 1'b1) begin
                n_fail++;
                $display("FAIL cycles_phase step %0d: got %h/%b, expected %h/1", k, phase_a,
                         in_sync_a, ph[k]);
            end
            for (int i = 0; i < 2; i++) begin
                n_cmp++;
                if (obs_vec(i) !== exp_vec(i)) begin
                    n_fail++;
                    $display("FAIL cycles dut%0d step %0d: got %h, expected %h", i, k,
                             obs_vec(i), exp_vec(i));
                end
            end
        end
        n_cmp++;
        if (cycle_count_a !== 16'd3 || err_status_a !== 3'b000) begin
            n_fail++;
            $display("FAIL cycles_count: got %0d/%b, expected 3/000", cycle_count_a,
                     err_status_a);
        end
    endtask

    task automatic test_sync_yellow();
        logic [2:0] seq[3] = '{LY, LY, LG};
        logic [4:0] e[3]   = '{5'b0000_0, 5'b0000_0, 5'b0001_1};
        step(3'b000, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step(seq[k], 1'b0, 1'b0);
            n_cmp++;
            if ({phase_a, in_sync_a} !== e[k] || err_status_a !== 3'b000) begin
                n_fail++;
                $display("FAIL sync_yellow step %0d: got %b/%b, expected %b/000", k,
                         {phase_a, in_sync_a}, err_status_a, e[k]);
            end
            for (int i = 0; i < 2; i++) begin
                n_cmp++;
                if (obs_vec(i) !== exp_vec(i)) begin
                    n_fail++;
                    $display("FAIL sync_yellow dut%0d step %0d: got %h, expected %h", i, k,
                             obs_vec(i), exp_vec(i));
                end
            end
        end
    endtask

    task automatic test_seq_error();
        step(3'b000, 1'b0, 1'b1);
        step(LR, 1'b0, 1'b0);
        step(LG, 1'b0, 1'b0);
        n_cmp++;
        if (phase_a !== 4'd1 || err_seq_a !== 1'b1 || err_status_a !== 3'b010) begin
            n_fail++;
            $display("FAIL seq_err: got ph=%h seq=%b st=%b, expected 1/1/010", phase_a,
                     err_seq_a, err_status_a);
        end
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (obs_vec(i) !== exp_vec(i)) begin
                n_fail++;
                $display("FAIL seq_err dut%0d: got %h, expected %h", i, obs_vec(i), exp_vec(i));
            end
        end
        step(LY, 1'b1, 1'b0);
        n_cmp++;
        if (err_status_a !== 3'b000 || phase_a !== 4'd4) begin
            n_fail++;
            $display("FAIL seq_clr: got st=%b ph=%h, expected 000/4", err_status_a, phase_a);
        end
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (obs_vec(i) !== exp_vec(i)) begin
                n_fail++;
                $display("FAIL seq_clr dut%0d: got %h, expected %h", i, obs_vec(i), exp_vec(i));
            end
        end
    endtask

    task automatic test_combo();
        step(3'b000, 1'b0, 1'b1);
        step(LR, 1'b0, 1'b0);
        step(3'b110, 1'b0, 1'b0);
        n_cmp++;
        if (err_combo_a !== 1'b1 || phase_a !== 4'd0 || in_sync_a !== 1'b0) begin
            n_fail++;
            $display("FAIL combo_110: got c=%b ph=%h s=%b, expected 1/0/0", err_combo_a,
                     phase_a, in_sync_a);
        end
        step(3'b000, 1'b1, 1'b0);
        n_cmp++;
        if (err_combo_a !== 1'b1 || err_status_a !== 3'b001 || phase_a !== 4'd0) begin
            n_fail++;
            $display("FAIL combo_clr: got c=%b st=%b ph=%h, expected 1/001/0", err_combo_a,
                     err_status_a, phase_a);
        end
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (obs_vec(i) !== exp_vec(i)) begin
                n_fail++;
                $display("FAIL combo dut%0d: got %h, expected %h", i, obs_vec(i), exp_vec(i));
            end
        end
    endtask

    task automatic test_dwell();
        logic [2:0] seq[18] = '{LR, LR, LY, LY, LG, LG, LY, LY, LR, LY, LY,
                                LG, LG, LG, LG, LG, LG, LG};
        logic       dw[18]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0};
        step(3'b000, 1'b0, 1'b1);
        for (int k = 0; k < 18; k++) begin
            step(seq[k], 1'b0, 1'b0);
            n_cmp++;
            if (err_dwell_b !== dw[k]) begin
                n_fail++;
                $display("FAIL dwell step %0d: got %b, expected %b", k, err_dwell_b, dw[k]);
            end
            if (k == 9) begin
                n_cmp++;
                if (phase_b !== 4'd2 || cycle_count_b !== 16'd1) begin
                    n_fail++;
                    $display("FAIL dwell_short: got ph=%h cnt=%0d, expected 2/1", phase_b,
                             cycle_count_b);
                end
            end
            for (int i = 0; i < 2; i++) begin
                n_cmp++;
                if (obs_vec(i) !== exp_vec(i)) begin
                    n_fail++;
                    $display("FAIL dwell dut%0d step %0d: got %h, expected %h", i, k,
                             obs_vec(i), exp_vec(i));
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [2:0] seq[8] = '{LR, LY, LG, LY, LR, LG, LY, LY};
        step(3'b000, 1'b0, 1'b1);
        foreach (seq[k]) step(seq[k], 1'b0, 1'b0);
        step(3'($urandom_range(0, 7)), 1'b0, 1'b1);
        n_cmp++;
        if (phase_a !== 4'd0 || cycle_count_a !== 16'd0 || err_status_a !== 3'b000) begin
            n_fail++;
            $display("FAIL mid_reset: got ph=%h cnt=%0d st=%b, expected 0/0/000", phase_a,
                     cycle_count_a, err_status_a);
        end
        step(LR, 1'b0, 1'b0);
        n_cmp++;
        if (phase_a !== 4'd8 || in_sync_a !== 1'b1) begin
            n_fail++;
            $display("FAIL relock: got ph=%h s=%b, expected 8/1", phase_a, in_sync_a);
        end
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (obs_vec(i) !== exp_vec(i)) begin
                n_fail++;
                $display("FAIL relock dut%0d: got %h, expected %h", i, obs_vec(i), exp_vec(i));
            end
        end
    endtask

    task automatic test_random();
        logic [2:0] l;
        int unsigned r;
        step(3'b000, 1'b0, 1'b1);
        for (int k = 0; k < 800; k++) begin
            r = $urandom_range(0, 15);
            if (r == 0) begin
                l = 3'($urandom_range(0, 7));
            end else if (r < 3) begin
                l = 3'(1 << $urandom_range(0, 2));
            end else if (r < 9 && (last_lamp == LR || last_lamp == LY || last_lamp == LG)) begin
                l = last_lamp;
            end else begin
                case (last_lamp)
                    LR, LG:  l = LY;
                    LY:      l = (m_phase[0] == 4) ? LR : LG;
                    default: l = LR;
                endcase
            end
            step(l, ($urandom_range(0, 7) == 0), ($urandom_range(0, 99) == 0));
            for (int i = 0; i < 2; i++) begin
                n_cmp++;
                if (obs_vec(i) !== exp_vec(i)) begin
                    n_fail++;
                    $display("FAIL random dut%0d step %0d lamp %b: got %h, expected %h", i, k,
                             l, obs_vec(i), exp_vec(i));
                end
            end
        end
    endtask

    initial begin
        last_lamp = 3'b000;
        for (int i = 0; i < 2; i++) model_step(i, 3'b000, 1'b0, 1'b1);
        test_reset();
        test_cycles();
        test_sync_yellow();
        test_seq_error();
        test_combo();
        test_dwell();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
